fbcpu_memory: RTL and testbench
===============================

Name: fbcpu_memory

Overview:
- Memory-side responder for the FB-CPU core memory bus (MAR / RAMWr / MDRIn / MDROut).
- Contains a single-port word RAM with registered read, two memory-mapped I/O locations, and a boot sequencer.
- The boot sequencer clears RAM, then accepts a program over a valid/ready loader stream, then releases the CPU.
- Sits beside the core in the top level; the core's ports connect to it directly.

Parameters:
ADDRESS_WIDTH, 6, width of MAR; RAM depth DEPTH = 2**ADDRESS_WIDTH words
DATA_WIDTH, 10, word width of RAM, MDRIn, MDROut, loader and I/O data

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
MAR  in  ADDRESS_WIDTH  CPU address
RAMWr  in  1  CPU write enable
MDRIn  in  DATA_WIDTH  CPU write data
MDROut  out  DATA_WIDTH  CPU read data, registered
cpu_hold  out  1  high while not in RUN; drives the core's rst
ld_valid  in  1  loader word valid
ld_data  in  DATA_WIDTH  loader word
ld_last  in  1  marks final program word
ld_ready  out  1  loader word accepted when ld_valid && ld_ready
io_in  in  DATA_WIDTH  external input, readable at IO_IN_ADDR
io_out  out  DATA_WIDTH  output register, written at IO_OUT_ADDR
io_out_strobe  out  1  one-cycle pulse per CPU write to IO_OUT_ADDR
boot_state  out  2  current state encoding, for debug

Behaviour:
- Address map:
  - 0..DEPTH-3: RAM.
  - IO_OUT_ADDR = DEPTH-2 (62): io_out register; a write does not touch the RAM word.
  - IO_IN_ADDR = DEPTH-1 (63): read returns io_in; writes are ignored.
- Reset (rst=1 at an edge), from any state including mid-load:
  - state=CLEAR, clear_addr=0, ld_addr=0.
  - MDROut=0, io_out=0, io_out_strobe=0, ld_ready=0, cpu_hold=1.
  - RAM contents are not reset directly; CLEAR rewrites them.
- CLEAR (boot_state=0):
  - Writes 0 to mem[clear_addr] each cycle and increments clear_addr.
  - After writing DEPTH-3 (61), goes to LOAD. Takes exactly DEPTH-2 cycles.
  - ld_ready=0; CPU bus ignored; MDROut=0.
- LOAD (boot_state=1):
  - ld_ready=1. Each accepted word writes mem[ld_addr] <= ld_data, then ld_addr++.
  - Goes to RUN on acceptance of a word with ld_last=1, or of the word at ld_addr=DEPTH-3 (overflow guard; ld_last is ignored there).
  - Idle cycles (ld_valid=0) are unbounded; state is held.
  - CPU bus ignored; MDROut=0.
- RUN (boot_state=2): ld_ready=0 and cpu_hold=0. Remains in RUN until rst. Encoding 3 is unused and returns to CLEAR.
- cpu_hold is a registered function of state, so the core leaves reset the cycle after RUN is entered.
- CPU read (RUN only):
  - At each edge, MDROut <= value at MAR: mem[MAR], io_out if MAR=62, io_in if MAR=63.
  - One-cycle latency. MAR presented in one core state yields valid MDROut in the next.
  - MDROut holds its last value when not updated.
- CPU write (RUN, RAMWr=1): at the edge, mem[MAR] <= MDRIn for MAR < 62.
  - MAR=62: io_out <= MDRIn and io_out_strobe=1 for the following cycle only.
  - MAR=63: no effect.
- Read and write to the same address in one cycle are read-first: MDROut returns the old value.
- Back-to-back writes to 62 give a strobe on every cycle.
- All arithmetic on clear_addr and ld_addr is ADDRESS_WIDTH bits; neither can wrap because of the terminal checks.

Decomposition:
- Shared package fbcpu_pkg holds:
  - boot state enum CLEAR=0, LOAD=1, RUN=2;
  - IO_OUT_ADDR and IO_IN_ADDR expressed as DEPTH-2 and DEPTH-1;
  - default ADDRESS_WIDTH and DATA_WIDTH.
- Sub-module fbcpu_ram_sp: single write port, registered read-first read port; the array lives here.
- The top module muxes the write port between the clear, loader and CPU sources, and muxes read data with the I/O registers.

Test Plan:
1. Reset, then count cycles -> ld_ready rises exactly 62 cycles after rst deasserts; cpu_hold=1 throughout; MDROut=0.
2. Load 3 words 0x005, 0x144, 0x3FF with ld_last on the third, inserting ld_valid gaps -> boot_state=2. In RUN, reading MAR=0,1,2,3 gives 0x005, 0x144, 0x3FF, 0x000 with one-cycle latency.
3. Stream 70 words with ld_last=0 -> only 62 accepted (ld_ready drops after word 61); mem[61] holds word 61; words 62 onward are not accepted.
4. RUN: write 0x2AA to MAR=62 -> io_out=0x2AA, io_out_strobe high exactly one cycle. Read MAR=62 -> 0x2AA. With io_in=0x155, read MAR=63 -> 0x155. Write to 63 -> no change anywhere.
5. RUN: mem[10]=0x011; same cycle RAMWr=1, MAR=10, MDRIn=0x0F0 -> MDROut=0x011; next read of 10 -> 0x0F0.
6. Assert rst midway through a load, after 2 words -> returns to CLEAR; full 62-cycle clear; reloading 1 word (ld_last=1) leaves mem[1]=0.

Source files
------------

// File: rtl/fbcpu_pkg.sv
// Shared types and address-map constants for the FB-CPU memory-side block.
package fbcpu_pkg;

    localparam int unsigned ADDRESS_WIDTH_DEF = 6;
    localparam int unsigned DATA_WIDTH_DEF    = 10;
    localparam int unsigned DEPTH_DEF         = 1 << ADDRESS_WIDTH_DEF;

    // Top two words of the address space are memory-mapped I/O.
    localparam int unsigned IO_OUT_ADDR = DEPTH_DEF - 2;
    localparam int unsigned IO_IN_ADDR  = DEPTH_DEF - 1;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } boot_state_e;

    // Which registered source MDROut presents this cycle.
    typedef enum logic [1:0] {
        MDR_ZERO = 2'd0,
        MDR_RAM  = 2'd1,
        MDR_IO   = 2'd2
    } mdr_src_e;

    function automatic int unsigned io_out_addr(input int unsigned aw);
        return (1 << aw) - 2;
    endfunction

    function automatic int unsigned io_in_addr(input int unsigned aw);
        return (1 << aw) - 1;
    endfunction

endpackage

// File: rtl/fbcpu_ram_sp.sv
// Single-port word RAM: one write port, registered read-first read port.
module fbcpu_ram_sp #(
    parameter int unsigned ADDRESS_WIDTH = 6,
    parameter int unsigned DATA_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Combinational read of the addressed word (old contents on a write cycle).
    always_comb begin
        rdata_d = mem[addr];
    end

    // Array write and read-data register; read sees pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fbcpu_memory.sv
// Memory-side responder for the FB-CPU bus: RAM, two I/O words, boot sequencer.
module fbcpu_memory
    import fbcpu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] MAR,
    input  logic                     RAMWr,
    input  logic [DATA_WIDTH-1:0]    MDRIn,
    output logic [DATA_WIDTH-1:0]    MDROut,
    output logic                     cpu_hold,
    input  logic                     ld_valid,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     ld_last,
    output logic                     ld_ready,
    input  logic [DATA_WIDTH-1:0]    io_in,
    output logic [DATA_WIDTH-1:0]    io_out,
    output logic                     io_out_strobe,
    output logic [1:0]               boot_state
);

    localparam logic [ADDRESS_WIDTH-1:0] MAP_IO_OUT   = ADDRESS_WIDTH'(io_out_addr(ADDRESS_WIDTH));
    localparam logic [ADDRESS_WIDTH-1:0] MAP_IO_IN    = ADDRESS_WIDTH'(io_in_addr(ADDRESS_WIDTH));
    localparam logic [ADDRESS_WIDTH-1:0] MAP_LAST_RAM = ADDRESS_WIDTH'(io_out_addr(ADDRESS_WIDTH) - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE     = ADDRESS_WIDTH'(1);

    boot_state_e               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]  clear_addr_q, clear_addr_d;
    logic [ADDRESS_WIDTH-1:0]  ld_addr_q, ld_addr_d;
    logic [DATA_WIDTH-1:0]     io_out_q, io_out_d;
    logic                      strobe_q, strobe_d;
    logic                      cpu_hold_q, cpu_hold_d;
    mdr_src_e                  mdr_src_q, mdr_src_d;
    logic [DATA_WIDTH-1:0]     io_rd_q, io_rd_d;

    logic                      ram_we;
    logic [ADDRESS_WIDTH-1:0]  ram_addr;
    logic [DATA_WIDTH-1:0]     ram_wdata;
    logic [DATA_WIDTH-1:0]     ram_rdata;

    fbcpu_ram_sp #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Boot sequencing, RAM write-port mux and CPU read/write decode.
    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        ld_addr_d    = ld_addr_q;
        io_out_d     = io_out_q;
        strobe_d     = 1'b0;
        mdr_src_d    = MDR_ZERO;
        io_rd_d      = io_rd_q;
        ram_we       = 1'b0;
        ram_addr     = MAR;
        ram_wdata    = MDRIn;
        ld_ready     = 1'b0;

        case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clear_addr_q;
                ram_wdata = '0;
                if (clear_addr_q == MAP_LAST_RAM) begin
                    state_d = LOAD;
                end else begin
                    clear_addr_d = clear_addr_q + ADDR_ONE;
                end
            end
            LOAD: begin
                ld_ready  = 1'b1;
                ram_addr  = ld_addr_q;
                ram_wdata = ld_data;
                if (ld_valid) begin
                    ram_we    = 1'b1;
                    ld_addr_d = ld_addr_q + ADDR_ONE;
                    if (ld_last || ld_addr_q == MAP_LAST_RAM) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                ram_we = RAMWr && (MAR < MAP_IO_OUT);
                if (RAMWr && MAR == MAP_IO_OUT) begin
                    io_out_d = MDRIn;
                    strobe_d = 1'b1;
                end
                // I/O reads capture the pre-write value so they stay read-first too.
                if (MAR == MAP_IO_OUT) begin
                    mdr_src_d = MDR_IO;
                    io_rd_d   = io_out_q;
                end else if (MAR == MAP_IO_IN) begin
                    mdr_src_d = MDR_IO;
                    io_rd_d   = io_in;
                end else begin
                    mdr_src_d = MDR_RAM;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        cpu_hold_d = (state_q != RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clear_addr_q <= '0;
            ld_addr_q    <= '0;
            io_out_q     <= '0;
            strobe_q     <= 1'b0;
            cpu_hold_q   <= 1'b1;
            mdr_src_q    <= MDR_ZERO;
            io_rd_q      <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            ld_addr_q    <= ld_addr_d;
            io_out_q     <= io_out_d;
            strobe_q     <= strobe_d;
            cpu_hold_q   <= cpu_hold_d;
            mdr_src_q    <= mdr_src_d;
            io_rd_q      <= io_rd_d;
        end
    end

    // Read data selected from registered sources only, so MDROut has no path from MAR.
    always_comb begin
        case (mdr_src_q)
            MDR_RAM: MDROut = ram_rdata;
            MDR_IO:  MDROut = io_rd_q;
            default: MDROut = '0;
        endcase
    end

    assign cpu_hold      = cpu_hold_q;
    assign io_out        = io_out_q;
    assign io_out_strobe = strobe_q;
    assign boot_state    = state_q;

endmodule

// File: tb/tb_fbcpu_memory.sv
// Directed self-checking bench for fbcpu_memory with a read-data scoreboard.
module tb_fbcpu_memory;

    localparam int AW = 6;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] MAR;
    logic          RAMWr;
    logic [DW-1:0] MDRIn;
    logic [DW-1:0] MDROut;
    logic          cpu_hold;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic [DW-1:0] io_in;
    logic [DW-1:0] io_out;
    logic          io_out_strobe;
    logic [1:0]    boot_state;

    fbcpu_memory #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .MAR           (MAR),
        .RAMWr         (RAMWr),
        .MDRIn         (MDRIn),
        .MDROut        (MDROut),
        .cpu_hold      (cpu_hold),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .ld_last       (ld_last),
        .ld_ready      (ld_ready),
        .io_in         (io_in),
        .io_out        (io_out),
        .io_out_strobe (io_out_strobe),
        .boot_state    (boot_state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [DW-1:0] model_mem [64];
    logic [DW-1:0] io_out_m;
    int            ld_idx;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] model_read(input int a);
        if (a == 62) return io_out_m;
        if (a == 63) return io_in;
        return model_mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        io_out_m = '0;
        ld_idx   = 0;
    endtask

    // Waits (bounded) for ld_ready after rst drops; checks cycle count and hold/zero.
    task automatic wait_clear(input string tag);
        int cyc;
        int bad;
        cyc = 0;
        bad = 0;
        while (ld_ready !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
            if (ld_ready !== 1'b1 && (cpu_hold !== 1'b1 || MDROut !== '0 || boot_state !== 2'd0)) bad++;
        end
        check({tag, "_cycles"}, cyc, 62);
        check({tag, "_hold_zero"}, bad, 0);
        check({tag, "_state_load"}, boot_state, 2'd1);
    endtask

    task automatic ld_word(input logic [DW-1:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        model_mem[ld_idx] = d;
        ld_idx++;
    endtask

    task automatic rd(input int a);
        MAR   = AW'(a);
        RAMWr = 1'b0;
        exp_q.push_back(model_read(a));
        step();
        check($sformatf("read_%0d", a), MDROut, exp_q.pop_front());
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        MAR   = AW'(a);
        RAMWr = 1'b1;
        MDRIn = d;
        exp_q.push_back(model_read(a));
        step();
        RAMWr = 1'b0;
        if (a < 62) model_mem[a] = d;
        else if (a == 62) io_out_m = d;
        check($sformatf("wr_readfirst_%0d", a), MDROut, exp_q.pop_front());
    endtask

    initial begin
        int acc;
        rst = 1'b1; MAR = '0; RAMWr = 1'b0; MDRIn = '0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; io_in = '0;
        model_clear();
        step();
        step();

        // 1: reset values and clear duration
        check("rst_state", boot_state, 2'd0);
        check("rst_hold", cpu_hold, 1'b1);
        check("rst_ready", ld_ready, 1'b0);
        check("rst_mdr", MDROut, '0);
        check("rst_io_out", io_out, '0);
        check("rst_strobe", io_out_strobe, 1'b0);
        rst = 1'b0;
        wait_clear("clear1");

        // 2: load with gaps, then read back with one-cycle latency
        ld_word(10'h005, 1'b0);
        step();
        step();
        ld_word(10'h144, 1'b0);
        step();
        check("load_idle_state", boot_state, 2'd1);
        ld_word(10'h3FF, 1'b1);
        check("run_state", boot_state, 2'd2);
        check("run_ready_low", ld_ready, 1'b0);
        check("hold_lag", cpu_hold, 1'b1);
        rd(0);
        check("hold_released", cpu_hold, 1'b0);
        rd(1);
        rd(2);
        rd(3);

        // 4: I/O locations
        wr(62, 10'h2AA);
        check("io_out_val", io_out, 10'h2AA);
        check("strobe_hi", io_out_strobe, 1'b1);
        rd(62);
        check("strobe_one_cycle", io_out_strobe, 1'b0);
        wr(62, 10'h0C3);
        check("strobe_b2b_1", io_out_strobe, 1'b1);
        wr(62, 10'h2AA);
        check("strobe_b2b_2", io_out_strobe, 1'b1);
        io_in = 10'h155;
        rd(63);
        wr(63, 10'h3C3);
        check("wr63_io_out", io_out, 10'h2AA);
        check("wr63_strobe", io_out_strobe, 1'b0);
        rd(63);
        rd(61);
        rd(62);

        // 5: read-first on a same-address write
        wr(10, 10'h011);
        wr(10, 10'h0F0);
        rd(10);
        rd(2);

        // 3: overflow guard on a 70-word stream
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        wait_clear("clear2");
        acc = 0;
        for (int i = 0; i < 70; i++) begin
            ld_valid = 1'b1;
            ld_data  = DW'(10'h100 + i);
            ld_last  = 1'b0;
            if (ld_ready === 1'b1) acc++;
            step();
        end
        ld_valid = 1'b0;
        for (int i = 0; i < 62; i++) model_mem[i] = DW'(10'h100 + i);
        check("ovf_accepted", acc, 62);
        check("ovf_state", boot_state, 2'd2);
        check("ovf_io_out", io_out, '0);
        rd(0);
        rd(60);
        rd(61);
        rd(62);

        // 6: reset mid-load, full reclear, short reload
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        wait_clear("clear3");
        ld_word(10'h1A1, 1'b0);
        ld_word(10'h2B2, 1'b0);
        rst = 1'b1;
        step();
        check("midload_state", boot_state, 2'd0);
        check("midload_ready", ld_ready, 1'b0);
        check("midload_hold", cpu_hold, 1'b1);
        rst = 1'b0;
        model_clear();
        wait_clear("clear4");
        ld_word(10'h2B5, 1'b1);
        check("reload_state", boot_state, 2'd2);
        rd(0);
        rd(1);
        rd(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
